// File: rtl/sprite_mover_if.sv
// Plotter-side bundle for sprite_mover: control inputs plus the pixel write port.
interface sprite_mover_if;
    logic       go;
    logic       pause;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic [2:0] current_state;

    // Driver of go/pause/colour, consumer of the pixel stream.
    modport master (
        output go, pause, colour_in,
        input  x, y, colour, writeEn, busy, current_state
    );

    // The animator itself.
    modport slave (
        input  go, pause, colour_in,
        output x, y, colour, writeEn, busy, current_state
    );
endinterface

// File: rtl/sprite_mover.sv
// Single-sprite animator: draw, hold, erase, step with edge bounce, repeat.
module sprite_mover #(
    parameter int unsigned SPRITE_W        = 8,
    parameter int unsigned SPRITE_H        = 8,
    parameter int unsigned SCREEN_W        = 160,
    parameter int unsigned SCREEN_H        = 120,
    parameter int unsigned TICKS_PER_FRAME = 833334,
    parameter int unsigned FRAMES_PER_STEP = 15,
    parameter int unsigned STEP            = 1,
    parameter int unsigned X_INIT          = 0,
    parameter int unsigned Y_INIT          = 0
) (
    input logic           CLOCK,
    input logic           resetn,
    sprite_mover_if.slave bus
);

    localparam int unsigned XMAX = SCREEN_W - SPRITE_W;
    localparam int unsigned YMAX = SCREEN_H - SPRITE_H;
    localparam int unsigned TW   = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int unsigned FW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [4:0]    CX_LAST    = 5'(SPRITE_W - 1);
    localparam logic [4:0]    CY_LAST    = 5'(SPRITE_H - 1);
    localparam logic [TW-1:0] TICK_LOAD  = TW'(TICKS_PER_FRAME - 1);
    localparam logic [FW-1:0] FRAME_LOAD = FW'(FRAMES_PER_STEP - 1);
    localparam logic [8:0]    XMAX_EXT   = 9'(XMAX);
    localparam logic [7:0]    XMAX_PX    = 8'(XMAX);
    localparam logic [7:0]    YMAX_EXT   = 8'(YMAX);
    localparam logic [6:0]    YMAX_PY    = 7'(YMAX);
    localparam logic [7:0]    STEP_PX    = 8'(STEP);
    localparam logic [6:0]    STEP_PY    = 7'(STEP);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StDraw  = 3'd2,
        StWait  = 3'd3,
        StErase = 3'd4,
        StMove  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    px_q, px_d;
    logic [6:0]    py_q, py_d;
    logic          dx_q, dx_d;
    logic          dy_q, dy_d;
    logic [4:0]    cx_q, cx_d;
    logic [4:0]    cy_q, cy_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [2:0]    colour_q, colour_d;

    // One extra bit so a forward step near the edge cannot wrap before the compare.
    logic [8:0] px_fwd;
    logic [7:0] py_fwd;
    assign px_fwd = {1'b0, px_q} + {1'b0, STEP_PX};
    assign py_fwd = {1'b0, py_q} + {1'b0, STEP_PY};

    // State and datapath registers.
    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            px_q     <= 8'(X_INIT);
            py_q     <= 7'(Y_INIT);
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            cx_q     <= '0;
            cy_q     <= '0;
            tick_q   <= TICK_LOAD;
            frame_q  <= FRAME_LOAD;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            colour_q <= colour_d;
        end
    end

    // Next-state: sequencing, raster walk, frame timer and bounce step.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        tick_d   = tick_q;
        frame_d  = frame_q;
        colour_d = colour_q;

        case (state_q)
            StIdle: begin
                if (bus.go) state_d = StArm;
            end
            StArm: begin
                if (!bus.go) begin
                    state_d  = StDraw;
                    colour_d = bus.colour_in;
                end
            end
            StDraw, StErase: begin
                if (cx_q == CX_LAST) begin
                    cx_d = '0;
                    if (cy_q == CY_LAST) begin
                        cy_d    = '0;
                        state_d = (state_q == StDraw) ? StWait : StMove;
                    end else begin
                        cy_d = cy_q + 5'd1;
                    end
                end else begin
                    cx_d = cx_q + 5'd1;
                end
            end
            StWait: begin
                // Counters run down to zero and reload, so they are ready for the next hold.
                if (!bus.pause) begin
                    if (tick_q == '0) begin
                        tick_d = TICK_LOAD;
                        if (frame_q == '0) begin
                            frame_d = FRAME_LOAD;
                            state_d = StErase;
                        end else begin
                            frame_d = frame_q - 1'b1;
                        end
                    end else begin
                        tick_d = tick_q - 1'b1;
                    end
                end
            end
            StMove: begin
                if (dx_q) begin
                    if (px_fwd >= XMAX_EXT) begin
                        px_d = XMAX_PX;
                        dx_d = 1'b0;
                    end else begin
                        px_d = px_fwd[7:0];
                    end
                end else if (px_q <= STEP_PX) begin
                    px_d = '0;
                    dx_d = 1'b1;
                end else begin
                    px_d = px_q - STEP_PX;
                end

                if (dy_q) begin
                    if (py_fwd >= YMAX_EXT) begin
                        py_d = YMAX_PY;
                        dy_d = 1'b0;
                    end else begin
                        py_d = py_fwd[6:0];
                    end
                end else if (py_q <= STEP_PY) begin
                    py_d = '0;
                    dy_d = 1'b1;
                end else begin
                    py_d = py_q - STEP_PY;
                end

                state_d  = StDraw;
                colour_d = bus.colour_in;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel port and status, decoded straight from registered state.
    always_comb begin
        bus.x             = px_q + {3'b000, cx_q};
        bus.y             = py_q + {2'b00, cy_q};
        bus.writeEn       = (state_q == StDraw) || (state_q == StErase);
        bus.colour        = (state_q == StDraw) ? colour_q : 3'b000;
        bus.busy          = (state_q != StIdle) && (state_q != StArm);
        bus.current_state = state_q;
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover on a 16x12 screen with a 4x4 sprite.
module tb_sprite_mover;

    localparam int SW    = 4;
    localparam int SH    = 4;
    localparam int SCRW  = 16;
    localparam int SCRH  = 12;
    localparam int TPF   = 3;
    localparam int FPS   = 2;
    localparam int STEPV = 2;
    localparam int XI    = 10;
    localparam int YI    = 6;
    localparam int XMAXV = SCRW - SW;
    localparam int YMAXV = SCRH - SH;

    logic clk = 1'b0;
    logic rst_n;

    sprite_mover_if sm_if ();

    sprite_mover #(
        .SPRITE_W        (SW),
        .SPRITE_H        (SH),
        .SCREEN_W        (SCRW),
        .SCREEN_H        (SCRH),
        .TICKS_PER_FRAME (TPF),
        .FRAMES_PER_STEP (FPS),
        .STEP            (STEPV),
        .X_INIT          (XI),
        .Y_INIT          (YI)
    ) dut (
        .CLOCK  (clk),
        .resetn (rst_n),
        .bus    (sm_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase code, index within the current burst, origin and heading.
    int m_ph  = 0;
    int m_n   = 0;
    int m_w   = 0;
    int m_px  = XI;
    int m_py  = YI;
    int m_dx  = 1;
    int m_dy  = 1;
    int m_col = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_n <= 0; m_w <= 0;
            m_px <= XI; m_py <= YI; m_dx <= 1; m_dy <= 1; m_col <= 0;
        end else begin
            case (m_ph)
                0: if (sm_if.go) m_ph <= 1;
                1: if (!sm_if.go) begin m_ph <= 2; m_n <= 0; m_col <= int'(sm_if.colour_in); end
                2: if (m_n == SW * SH - 1) begin m_ph <= 3; m_n <= 0; m_w <= 0; end
                   else m_n <= m_n + 1;
                3: if (!sm_if.pause) begin
                       if (m_w == TPF * FPS - 1) begin m_ph <= 4; m_n <= 0; end
                       else m_w <= m_w + 1;
                   end
                4: if (m_n == SW * SH - 1) begin m_ph <= 5; m_n <= 0; end
                   else m_n <= m_n + 1;
                5: begin
                    if (m_dx == 1) begin
                        if (m_px + STEPV >= XMAXV) begin m_px <= XMAXV; m_dx <= 0; end
                        else m_px <= m_px + STEPV;
                    end else if (m_px <= STEPV) begin m_px <= 0; m_dx <= 1; end
                    else m_px <= m_px - STEPV;
                    if (m_dy == 1) begin
                        if (m_py + STEPV >= YMAXV) begin m_py <= YMAXV; m_dy <= 0; end
                        else m_py <= m_py + STEPV;
                    end else if (m_py <= STEPV) begin m_py <= 0; m_dy <= 1; end
                    else m_py <= m_py - STEPV;
                    m_ph  <= 2;
                    m_n   <= 0;
                    m_col <= int'(sm_if.colour_in);
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // Every-cycle comparison of the DUT pixel port against the model.
    always @(negedge clk) begin
        chk("state",   int'(sm_if.current_state), m_ph);
        chk("x",       int'(sm_if.x), m_px + (m_n % SW));
        chk("y",       int'(sm_if.y), m_py + (m_n / SW));
        chk("writeEn", int'(sm_if.writeEn), (m_ph == 2 || m_ph == 4) ? 1 : 0);
        chk("colour",  int'(sm_if.colour), (m_ph == 2) ? m_col : 0);
        chk("busy",    int'(sm_if.busy), (m_ph >= 2) ? 1 : 0);
    end

    // Run-length of each state as seen on the DUT, recorded when the state is left.
    int prev_st = 0;
    int run_len = 0;
    int last_len[8];

    always @(negedge clk) begin
        if (int'(sm_if.current_state) == prev_st) begin
            run_len <= run_len + 1;
        end else begin
            last_len[prev_st] <= run_len;
            prev_st           <= int'(sm_if.current_state);
            run_len           <= 1;
        end
    end

    task automatic wait_state(input int s, input int budget);
        int k = 0;
        while (int'(sm_if.current_state) != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_state", int'(sm_if.current_state), s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) last_len[i] = 0;
        rst_n           = 1'b0;
        sm_if.go        = 1'b0;
        sm_if.pause     = 1'b0;
        sm_if.colour_in = 3'b101;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_x", int'(sm_if.x), 10);
        chk("rst_y", int'(sm_if.y), 6);
        chk("rst_busy", int'(sm_if.busy), 0);
        chk("rst_we", int'(sm_if.writeEn), 0);
        chk("rst_state", int'(sm_if.current_state), 0);

        // go high for three sampled edges, then released.
        @(posedge clk); #1 sm_if.go = 1'b1;
        repeat (3) @(posedge clk);
        #1 sm_if.go = 1'b0;

        wait_state(2, 20);
        #1;
        chk("arm_len", last_len[1], 3);
        chk("draw0_x", int'(sm_if.x), 10);
        chk("draw0_y", int'(sm_if.y), 6);
        chk("draw0_col", int'(sm_if.colour), 5);
        chk("draw0_busy", int'(sm_if.busy), 1);

        // Mid-draw disturbances: go pulse, colour change, pause; none may alter the burst.
        for (int i = 1; i < SW * SH; i++) begin
            @(posedge clk); #1;
            if (i == 3) sm_if.go = 1'b1;
            if (i == 5) sm_if.go = 1'b0;
            if (i == 8) sm_if.colour_in = 3'b010;
            if (i == 10) sm_if.pause = 1'b1;
            if (i == 13) sm_if.pause = 1'b0;
            @(negedge clk);
        end
        chk("draw15_x", int'(sm_if.x), 13);
        chk("draw15_y", int'(sm_if.y), 9);
        chk("draw15_col", int'(sm_if.colour), 5);

        wait_state(3, 5);
        @(posedge clk); #1 sm_if.go = 1'b1;
        @(posedge clk); #1 sm_if.go = 1'b0;

        wait_state(4, 20);
        #1;
        chk("draw_len", last_len[2], 16);
        chk("wait_len", last_len[3], 6);
        chk("erase0_x", int'(sm_if.x), 10);
        chk("erase0_y", int'(sm_if.y), 6);
        chk("erase0_col", int'(sm_if.colour), 0);
        chk("erase0_we", int'(sm_if.writeEn), 1);

        wait_state(5, 30);
        #1 chk("erase_len", last_len[4], 16);

        wait_state(2, 5);
        #1;
        chk("move_len", last_len[5], 1);
        chk("bounce_x", int'(sm_if.x), 12);
        chk("bounce_y", int'(sm_if.y), 8);
        chk("draw2_col", int'(sm_if.colour), 2);

        // Pause for 20 sampled cycles inside the hold.
        wait_state(3, 30);
        @(posedge clk); #1 sm_if.pause = 1'b1;
        repeat (20) @(posedge clk);
        #1 sm_if.pause = 1'b0;

        wait_state(4, 40);
        #1 chk("pause_wait_len", last_len[3], 26);

        wait_state(2, 40);
        #1;
        chk("back_x", int'(sm_if.x), 10);
        chk("back_y", int'(sm_if.y), 6);
        chk("draw3_col", int'(sm_if.colour), 2);

        // Asynchronous reset on the seventh pixel of this draw.
        repeat (6) @(negedge clk);
        #1 chk("pre_rst_we", int'(sm_if.writeEn), 1);
        rst_n = 1'b0;
        #1;
        chk("async_we", int'(sm_if.writeEn), 0);
        chk("async_state", int'(sm_if.current_state), 0);
        chk("async_busy", int'(sm_if.busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_x", int'(sm_if.x), 10);
        chk("post_y", int'(sm_if.y), 6);
        chk("post_busy", int'(sm_if.busy), 0);
        chk("post_state", int'(sm_if.current_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised single-sprite animator for the 160x120, 3-bit-colour VGA plotter path. Draws a solid rectangular sprite pixel-by-pixel, holds it for a programmable number of frame periods, erases it to black, advances its position on both axes with independent bounce at the screen edges, and repeats. Its pixel outputs drive the VGA adapter write port directly. It is the generalised successor to the fixed 8x8 horizontal-only mover.

## Interface
Parameters:
- SPRITE_W, 8: sprite width in pixels (1..32).
- SPRITE_H, 8: sprite height in pixels (1..32).
- SCREEN_W, 160: screen width; x range 0..SCREEN_W-1.
- SCREEN_H, 120: screen height; y range 0..SCREEN_H-1.
- TICKS_PER_FRAME, 833334: clock cycles per frame tick (>=1).
- FRAMES_PER_STEP, 15: frame ticks per position step (>=1).
- STEP, 1: pixels moved per step on each axis (>=1, < SCREEN_W-SPRITE_W and < SCREEN_H-SPRITE_H).
- X_INIT, 0 and Y_INIT, 0: reset sprite origin (must be <= XMAX, YMAX).

Ports:
- CLOCK  in  1  system clock, all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- go  in  1  start request (level, released to begin).
- pause  in  1  freezes the WAIT timer while high.
- colour_in  in  3  sprite colour.
- x  out  8  pixel x to plotter.
- y  out  7  pixel y to plotter.
- colour  out  3  pixel colour to plotter.
- writeEn  out  1  plot strobe, one pixel per high cycle.
- busy  out  1  high in every state except IDLE and ARM.
- current_state  out  3  state encoding (debug).

## Operation
- XMAX = SCREEN_W-SPRITE_W, YMAX = SCREEN_H-SPRITE_H. Origin registers px, py; direction bits dx (1=right), dy (1=down); pixel counters cx (0..SPRITE_W-1), cy (0..SPRITE_H-1).
- x = px+cx, y = py+cy, combinational; both sums stay in range by construction.
- States (encoding): IDLE 0, ARM 1, DRAW 2, WAIT 3, ERASE 4, MOVE 5; codes 6-7 go to IDLE.
- IDLE: go=1 -> ARM. ARM: stays while go=1; go=0 -> DRAW; colour_in latched into colour register on ARM->DRAW and MOVE->DRAW transitions.
- DRAW: writeEn=1, colour=latched colour, raster order (cx fastest). After pixel (SPRITE_W-1,SPRITE_H-1): cx, cy clear, -> WAIT.
- WAIT: writeEn=0. tick counter counts TICKS_PER_FRAME cycles per frame; frame counter counts FRAMES_PER_STEP frames; on final cycle of final frame -> ERASE, counters reload. pause=1 holds both counters and state.
- ERASE: as DRAW but colour=3'b000; after last pixel -> MOVE.
- MOVE (1 cycle, writeEn=0): per axis independently. Right: if px+STEP >= XMAX then px=XMAX, dx=0 else px+=STEP. Left: if px <= STEP then px=0, dx=1 else px-=STEP. Same for py/dy against YMAX. -> DRAW.
- go is ignored outside IDLE/ARM; the block runs until reset. pause has no effect in DRAW/ERASE/MOVE.
- Reset values: state IDLE, px=X_INIT, py=Y_INIT, dx=1, dy=1, cx=cy=0, counters loaded, colour=0, writeEn=0, busy=0, so x=X_INIT, y=Y_INIT.

## Timing
- go falling edge -> first DRAW pixel on the cycle after ARM samples go=0.
- DRAW and ERASE each last exactly SPRITE_W*SPRITE_H cycles, writeEn high every cycle, no gaps.
- WAIT lasts exactly TICKS_PER_FRAME*FRAMES_PER_STEP cycles plus the number of cycles pause is sampled high.
- Full period: 2*SPRITE_W*SPRITE_H + TICKS_PER_FRAME*FRAMES_PER_STEP + 1 cycles.
- Asserting resetn=0 at any point drops writeEn and busy immediately (asynchronous); a partially drawn sprite is left on screen.

## Test plan
Bench parameters: SPRITE 4x4, SCREEN 16x12, TICKS_PER_FRAME 3, FRAMES_PER_STEP 2, STEP 2, X_INIT 10, Y_INIT 6 (XMAX 12, YMAX 8).
- Reset, go high 3 cycles then low, colour_in=3'b101 -> ARM held 3 cycles, then 16 writes x 10..13, y 6..9, x fastest, colour 101; busy rises with first write.
- Continue -> exactly 6 idle cycles, 16 erase writes colour 000 at same pixels, 1 MOVE cycle, redraw at origin (12,8) with both directions flipped; next cycle origin (10,6).
- Change colour_in to 3'b010 mid-DRAW -> current sprite stays 101; next DRAW uses 010.
- pause high for 20 cycles inside WAIT -> WAIT lasts 26 cycles; pause high during DRAW -> no change in 16-cycle write burst.
- go pulsed during WAIT/DRAW -> no effect on state sequence or timing.
- resetn low asynchronously on 7th DRAW pixel -> writeEn=0 and current_state=0 before next edge; after release x=10, y=6, busy=0, awaiting go.
